// File: rtl/servisia_mem_ctrl.sv
// Word-wide request/response to byte-beat controller for the external flash + SRAM pair.
// Define SERVISIA_MEM_WRITE_PROTECT_EN to reject flash writes with rsp_err_o instead of strobing.
`timescale 1ns/1ps
module servisia_mem_ctrl #(
   parameter int ADDR_W       = 21,
   parameter int FLASH_ADDR_W = 20,
   parameter int SRAM_ADDR_W  = 14,
   parameter int WORD_BYTES   = 4,
   parameter int FLASH_WAIT   = 3,
   parameter int SRAM_WAIT    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [ADDR_W-1:0]       req_addr_i,
   input  logic [8*WORD_BYTES-1:0] req_wdata_i,
   input  logic [WORD_BYTES-1:0]   req_be_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [8*WORD_BYTES-1:0] rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [FLASH_ADDR_W-1:0] ext_addr_o,
   output logic [7:0]              ext_wdata_o,
   output logic                    ext_wdata_oe_o,
   input  logic [7:0]              ext_rdata_i,
   output logic                    flash_ce_n_o,
   output logic                    flash_oe_n_o,
   output logic                    flash_we_n_o,
   output logic                    sram_cs_n_o,
   output logic                    sram_oe_n_o,
   output logic                    sram_we_n_o
);

   localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int DATA_W = 8 * WORD_BYTES;
   localparam logic [FLASH_ADDR_W-1:0] LANE_MASK    = FLASH_ADDR_W'(WORD_BYTES - 1);
   localparam logic [3:0]              FLASH_STROBE = 4'(FLASH_WAIT);
   localparam logic [3:0]              SRAM_STROBE  = 4'(SRAM_WAIT);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic                    we_q;
   logic                    region_q;
   logic [FLASH_ADDR_W-1:0] base_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [DATA_W-1:0]       rdata_q;
   logic [WORD_BYTES-1:0]   be_q;
   logic [LANE_W-1:0]       lane_q;
   logic [3:0]              cnt_q;

   logic [LANE_W-1:0]       first_lane;
   logic                    first_found;
   logic [LANE_W-1:0]       next_lane;
   logic                    next_found;
   logic                    protect_hit;
   logic [FLASH_ADDR_W-1:0] beat_addr;
   logic [7:0]              beat_byte;

`ifdef SERVISIA_MEM_WRITE_PROTECT_EN
   logic err_q;

   assign protect_hit = req_we_i && !req_addr_i[ADDR_W-1];
   assign rsp_err_o   = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (state == IDLE && req_valid_i) begin
         err_q <= protect_hit;
      end
   end
`else
   assign protect_hit = 1'b0;
   assign rsp_err_o   = 1'b0;
`endif

   // Reads visit every lane; writes only the lanes whose byte enable is set.
   always_comb begin
      first_lane  = '0;
      first_found = 1'b0;
      for (int k = WORD_BYTES - 1; k >= 0; k--) begin
         if (req_be_i[k] || !req_we_i) begin
            first_lane  = LANE_W'(k);
            first_found = 1'b1;
         end
      end
      next_lane  = '0;
      next_found = 1'b0;
      for (int k = WORD_BYTES - 1; k >= 0; k--) begin
         if ((k > int'(lane_q)) && (be_q[k] || !we_q)) begin
            next_lane  = LANE_W'(k);
            next_found = 1'b1;
         end
      end
   end

   assign beat_addr = region_q ?
                      FLASH_ADDR_W'(base_q[SRAM_ADDR_W-1:0] | SRAM_ADDR_W'(lane_q)) :
                      (base_q | FLASH_ADDR_W'(lane_q));
   assign beat_byte   = wdata_q[{lane_q, 3'b000} +: 8];
   assign rsp_rdata_o = rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      req_ready_o    = 1'b0;
      rsp_valid_o    = 1'b0;
      ext_addr_o     = '0;
      ext_wdata_o    = 8'h00;
      ext_wdata_oe_o = 1'b0;
      flash_ce_n_o   = 1'b1;
      flash_oe_n_o   = 1'b1;
      flash_we_n_o   = 1'b1;
      sram_cs_n_o    = 1'b1;
      sram_oe_n_o    = 1'b1;
      sram_we_n_o    = 1'b1;

      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_nxt = (protect_hit || !first_found) ? RESP : SETUP;
            end
         end
         SETUP: begin
            state_nxt = STROBE;
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            state_nxt = next_found ? SETUP : RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Address, select and write data stay put across SETUP/STROBE/HOLD of a beat.
      if (state == SETUP || state == STROBE || state == HOLD) begin
         ext_addr_o = beat_addr;
         if (region_q) begin
            sram_cs_n_o = 1'b0;
         end else begin
            flash_ce_n_o = 1'b0;
         end
         if (we_q) begin
            ext_wdata_o    = beat_byte;
            ext_wdata_oe_o = 1'b1;
         end
         if (state == STROBE) begin
            if (region_q) begin
               sram_we_n_o = !we_q;
               sram_oe_n_o = we_q;
            end else begin
               flash_we_n_o = !we_q;
               flash_oe_n_o = we_q;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q     <= 1'b0;
         region_q <= 1'b0;
         base_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         be_q     <= '0;
         lane_q   <= '0;
         cnt_q    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  we_q     <= req_we_i;
                  region_q <= req_addr_i[ADDR_W-1];
                  base_q   <= req_addr_i[FLASH_ADDR_W-1:0] & ~LANE_MASK;
                  wdata_q  <= req_wdata_i;
                  be_q     <= req_be_i;
                  lane_q   <= first_lane;
                  rdata_q  <= '0;
               end
            end
            SETUP: begin
               cnt_q <= region_q ? SRAM_STROBE : FLASH_STROBE;
            end
            STROBE: begin
               if (cnt_q == 4'd0) begin
                  if (!we_q) begin
                     rdata_q[{lane_q, 3'b000} +: 8] <= ext_rdata_i;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            HOLD: begin
               lane_q <= next_lane;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/servisia_mem_ctrl.md
Name: servisia_mem_ctrl

Overview:
- Parametrised external-memory controller for the byte-wide flash + SRAM pair.
- Turns one word-wide request/response transaction into a sequence of byte beats on the shared external bus.
- Each beat has programmable setup, strobe and hold timing per region; write lanes are masked by byte enables.
- Sits between the core's memory port and the external chips; owns all chip-select, strobe and tristate-enable pins.

Parameters:
- ADDR_W, 21, request byte-address width; MSB selects the region (0 = flash, 1 = SRAM).
- FLASH_ADDR_W, 20, address bits driven to the flash.
- SRAM_ADDR_W, 14, address bits driven to the SRAM.
- WORD_BYTES, 4, bytes per transaction word; power of two, 1..8.
- FLASH_WAIT, 3, extra strobe cycles for flash beats (0..15).
- SRAM_WAIT, 1, extra strobe cycles for SRAM beats (0..15).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address; low log2(WORD_BYTES) bits are ignored (word-aligned).
- req_wdata_i  in  8*WORD_BYTES  write data; lane k is bits [8k+7:8k].
- req_be_i  in  WORD_BYTES  write byte enables; ignored for reads.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid && ready.
- rsp_rdata_o  out  8*WORD_BYTES  read data; zero for writes.
- rsp_err_o  out  1  error flag (see Optional Feature).
- ext_addr_o  out  FLASH_ADDR_W  external address bus; SRAM uses the low SRAM_ADDR_W bits.
- ext_wdata_o  out  8  external write byte.
- ext_wdata_oe_o  out  1  tristate-buffer enable for the write byte.
- ext_rdata_i  in  8  external read byte.
- flash_ce_n_o, flash_oe_n_o, flash_we_n_o  out  1 each  flash controls, active-low.
- sram_cs_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM controls, active-low.

Behaviour:
- Reset values (rst_i high at a clock edge; wins over everything):
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - All *_n_o = 1; ext_wdata_oe_o=0; ext_addr_o=0; ext_wdata_o=0; FSM goes to IDLE.
  - Reset mid-beat aborts the transaction; no response is produced.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - req_ready_o=1.
  - On accept: latch we, word base (low bits cleared), wdata, be and region; lane:=0; go to SETUP.
  - If the request is a write with be==0, go directly to RESP (zero beats).
- Lane skipping (writes only): lanes with be[k]=0 are skipped with zero cycles spent. Reads always perform all WORD_BYTES beats, lanes 0..WORD_BYTES-1 in ascending order.
- SETUP (1 cycle):
  - ext_addr_o = base + lane; the selected chip's CE/CS is low; OE/WE are high.
  - Writes: ext_wdata_o = lane byte and ext_wdata_oe_o=1.
- STROBE (WAIT+1 cycles; WAIT comes from the latched region):
  - OE low for reads, WE low for writes; CE/CS stays low.
  - A 4-bit down-counter times the strobe.
  - Reads: ext_rdata_i is captured into lane k of the result on the last STROBE edge.
- HOLD (1 cycle):
  - OE/WE high; CE/CS, address and write data unchanged; ext_wdata_oe_o stays 1 for writes.
  - Then advance to the next enabled lane and go to SETUP, or go to RESP.
- RESP:
  - CE/CS high, ext_wdata_oe_o=0, rsp_valid_o=1, req_ready_o=0.
  - rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i; on handshake go to IDLE.
  - Response and new request never overlap: at most one outstanding transaction.
- Cycle counts:
  - Each beat costs WAIT+3 cycles.
  - Read latency from accept to rsp_valid_o = WORD_BYTES*(WAIT+3)+1 cycles.
- Pin invariants:
  - Flash and SRAM enables are never low simultaneously.
  - OE and WE are never low simultaneously.
  - ext_wdata_oe_o is never 1 while any OE is low.
- The unselected chip's pins stay at 1 throughout.
- Address wrap: base+lane never carries across the word base, because low bits are cleared.

Optional Feature:
- Macro: SERVISIA_MEM_WRITE_PROTECT_EN.
- Defined:
  - Writes to the flash region run zero beats (no flash strobe at all) and go straight to RESP with rsp_err_o=1.
  - SRAM writes and all reads are unaffected, with rsp_err_o=0.
- Undefined: flash writes proceed normally; rsp_err_o is tied to 0.

Test Plan:
- Reset: hold rst_i for 2 cycles mid-STROBE of a flash read -> next edge all *_n_o=1, ext_wdata_oe_o=0, rsp_valid_o=0, req_ready_o=1.
- SRAM read, addr 0x100002, WORD_BYTES=4, SRAM_WAIT=1:
  - Model returns 0x11,0x22,0x33,0x44 for addresses 0x0000..0x0003.
  - Required: rsp_rdata_o=0x44332211 exactly 17 cycles after accept; sram_oe_n_o low 2 cycles per beat.
- Flash write, addr 0x000040, wdata 0xAABBCCDD, be=4'b1010, FLASH_WAIT=3:
  - Required: exactly two beats, at 0x41 (0xCC) and 0x43 (0xAA); flash_we_n_o low 4 cycles each; rsp_err_o=0 (macro undefined).
- Write with be=0 -> rsp_valid_o one cycle after accept; no strobe or chip select toggles.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0; after handshake, req_ready_o=1 next cycle.
- With SERVISIA_MEM_WRITE_PROTECT_EN:
  - Flash write to 0x000010 -> rsp_err_o=1, flash_we_n_o never low.
  - SRAM write to 0x100010 -> rsp_err_o=0 and normal beats.
